// File: rtl/factorial_if.sv
// Start/done handshake bundle for the iterative factorial unit.
// The master issues requests and the slave (the engine) returns status and results.
interface factorial_if #(
  parameter int N_W = 8,
  parameter int R_W = 16
);
  logic           start;
  logic           abort;
  logic [N_W-1:0] x;
  logic           ready;
  logic           busy;
  logic           done;
  logic [R_W-1:0] result;
  logic           overflow;

  modport master (
    output start, abort, x,
    input  ready, busy, done, result, overflow
  );

  modport slave (
    input  start, abort, x,
    output ready, busy, done, result, overflow
  );
endinterface

// File: rtl/factorial_engine.sv
// Iterative X! unit: one multiply per clock, saturating on overflow, with
// a synchronous abort and a single-cycle done pulse.
module factorial_engine #(
  parameter int N_W = 8,
  parameter int R_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  factorial_if.slave bus
);

  localparam int P_W = R_W + N_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N_W-1:0] x_q, x_d;
  logic [N_W-1:0] i_q, i_d;
  logic [R_W-1:0] fi_q, fi_d;
  logic [R_W-1:0] result_q, result_d;
  logic           ovf_q, ovf_d;

  logic [N_W:0]   i_inc;
  logic [P_W-1:0] prod;

  function automatic logic prod_overflows(input logic [P_W-1:0] p);
    return |p[P_W-1:R_W];
  endfunction

  function automatic logic [R_W-1:0] saturate(input logic [P_W-1:0] p);
    if (prod_overflows(p)) begin
      return {R_W{1'b1}};
    end
    return p[R_W-1:0];
  endfunction

  // The counter never passes x_q, so the widened increment only matters
  // for the multiplier operand, never for wrap-around of i itself.
  assign i_inc = {1'b0, i_q} + {{N_W{1'b0}}, 1'b1};
  assign prod  = {{(N_W + 1){1'b0}}, fi_q} * {{R_W{1'b0}}, i_inc};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    i_d        = i_q;
    fi_d       = fi_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    bus.ready  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          x_d     = bus.x;
          i_d     = {{(N_W - 1){1'b0}}, 1'b1};
          fi_d    = {{(R_W - 1){1'b0}}, 1'b1};
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        bus.busy = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (i_q >= x_q) begin
          result_d = fi_q;
          state_d  = DONE;
        end else if (prod_overflows(prod)) begin
          result_d = saturate(prod);
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          fi_d = saturate(prod);
          i_d  = i_inc[N_W-1:0];
        end
      end

      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything so a reset
  // mid-run leaves no trace of the interrupted computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      i_q      <= '0;
      fi_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      i_q      <= i_d;
      fi_q     <= fi_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine: an 8/16 instance and a 4/32 instance
// sharing clock and reset, driven from vector tables plus corner sequences.
module tb_factorial_engine;

  logic clk;
  logic rst_n;

  factorial_if #(.N_W(8), .R_W(16)) bus_a ();
  factorial_if #(.N_W(4), .R_W(32)) bus_b ();

  factorial_engine #(.N_W(8), .R_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  factorial_engine #(.N_W(4), .R_W(32)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit sel;
  logic        cur_ready, cur_busy, cur_done, cur_ovf;
  logic [63:0] cur_result;

  assign cur_ready  = sel ? bus_b.ready    : bus_a.ready;
  assign cur_busy   = sel ? bus_b.busy     : bus_a.busy;
  assign cur_done   = sel ? bus_b.done     : bus_a.done;
  assign cur_ovf    = sel ? bus_b.overflow : bus_a.overflow;
  assign cur_result = sel ? 64'(bus_b.result) : 64'(bus_a.result);

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] x;
    logic [63:0] exp_result;
    logic        exp_ovf;
    int          exp_cycles;
  } vec_t;

  vec_t vec_a[8];
  vec_t vec_b[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [15:0] xv, input logic ab);
    if (sel) begin
      bus_b.start = st;
      bus_b.x     = xv[3:0];
      bus_b.abort = ab;
    end else begin
      bus_a.start = st;
      bus_a.x     = xv[7:0];
      bus_a.abort = ab;
    end
  endtask

  // One full transaction; cycles counts from the cycle after the accepting edge.
  task automatic run_op(input string name, input logic [15:0] xv,
                        input logic [63:0] exp_res, input logic exp_ovf, input int exp_cyc);
    int cyc;
    @(negedge clk);
    drive(1'b1, xv, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0);
    cyc = 1;
    chk({name, " ready_low"}, 64'(cur_ready), 64'd0);
    chk({name, " busy"}, 64'(cur_busy), 64'd1);
    chk({name, " ovf_clr"}, 64'(cur_ovf), 64'd0);
    while (!cur_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " done_seen"}, 64'(cur_done), 64'd1);
    chk({name, " latency"}, 64'(cyc), 64'(exp_cyc));
    chk({name, " result"}, cur_result, exp_res);
    chk({name, " overflow"}, 64'(cur_ovf), 64'(exp_ovf));
    @(negedge clk);
    chk({name, " done_once"}, 64'(cur_done), 64'd0);
    chk({name, " ready_back"}, 64'(cur_ready), 64'd1);
    chk({name, " result_hold"}, cur_result, exp_res);
  endtask

  initial begin
    int ready_seen;
    int cyc;
    int dones;

    vec_a[0] = '{16'd5, 64'd120,    1'b0, 6};
    vec_a[1] = '{16'd8, 64'd40320,  1'b0, 9};
    vec_a[2] = '{16'd0, 64'd1,      1'b0, 2};
    vec_a[3] = '{16'd1, 64'd1,      1'b0, 2};
    vec_a[4] = '{16'd2, 64'd2,      1'b0, 3};
    vec_a[5] = '{16'd7, 64'd5040,   1'b0, 8};
    vec_a[6] = '{16'd9, 64'hFFFF,   1'b1, 9};
    vec_a[7] = '{16'd4, 64'd24,     1'b0, 5};

    vec_b[0] = '{16'd15, 64'hFFFF_FFFF,  1'b1, 13};
    vec_b[1] = '{16'd12, 64'd479001600,  1'b0, 13};
    vec_b[2] = '{16'd0,  64'd1,          1'b0, 2};
    vec_b[3] = '{16'd3,  64'd6,          1'b0, 4};

    rst_n = 1'b0;
    sel   = 1'b0;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.x = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.x = '0;
    repeat (2) @(negedge clk);
    chk("rst ready", 64'(bus_a.ready), 64'd1);
    chk("rst busy", 64'(bus_a.busy), 64'd0);
    chk("rst result", 64'(bus_a.result), 64'd0);
    rst_n = 1'b1;

    // Reset mid-run after a completed computation left a nonzero result.
    run_op("pre_rst x3", 16'd3, 64'd6, 1'b0, 4);
    @(negedge clk);
    drive(1'b1, 16'd6, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'd0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst ready", 64'(cur_ready), 64'd1);
    chk("midrst busy", 64'(cur_busy), 64'd0);
    chk("midrst done", 64'(cur_done), 64'd0);
    chk("midrst result", cur_result, 64'd0);
    chk("midrst overflow", 64'(cur_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst x3", 16'd3, 64'd6, 1'b0, 4);

    foreach (vec_a[k]) begin
      run_op($sformatf("a x%0d", vec_a[k].x), vec_a[k].x, vec_a[k].exp_result,
             vec_a[k].exp_ovf, vec_a[k].exp_cycles);
    end

    // Abort on the third RUN cycle of x=7; previous result 24 must survive.
    @(negedge clk);
    drive(1'b1, 16'd7, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 16'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'd0, 1'b0);
    chk("abort ready", 64'(cur_ready), 64'd1);
    chk("abort busy", 64'(cur_busy), 64'd0);
    chk("abort done", 64'(cur_done), 64'd0);
    chk("abort result", cur_result, 64'd24);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (cur_done) dones++;
    end
    chk("abort no_done", 64'(dones), 64'd0);

    // Start held high, x changed mid-run: one computation on the captured x.
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      @(negedge clk);
      drive(1'b1, 16'd5, 1'b0);
      @(negedge clk);
      cyc = 1;
      ready_seen = 0;
      while (!cur_done && cyc < 400) begin
        if (cyc == 2) drive(1'b1, 16'd3, 1'b0);
        if (cur_ready) ready_seen++;
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("hold%0d latency", s), 64'(cyc), 64'd6);
      chk($sformatf("hold%0d result", s), cur_result, 64'd120);
      chk($sformatf("hold%0d no_ready", s), 64'(ready_seen), 64'd0);
      @(negedge clk);
      chk($sformatf("hold%0d ready_back", s), 64'(cur_ready), 64'd1);
      @(negedge clk);
      drive(1'b0, 16'd0, 1'b0);
      chk($sformatf("hold%0d reaccept", s), 64'(cur_busy), 64'd1);
      cyc = 1;
      while (!cur_done && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("hold%0d second_lat", s), 64'(cyc), 64'd4);
      chk($sformatf("hold%0d second_res", s), cur_result, 64'd6);
      @(negedge clk);
    end

    sel = 1'b1;
    foreach (vec_b[k]) begin
      run_op($sformatf("b x%0d", vec_b[k].x), vec_b[k].x, vec_b[k].exp_result,
             vec_b[k].exp_ovf, vec_b[k].exp_cycles);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/factorial_engine.md
# factorial_engine

Self-contained, parametrised iterative factorial unit with its own controller. It computes X! one multiply per clock and reports the result through a start/done handshake. It detects result overflow and saturates, and it supports a synchronous abort. It replaces the fixed 8-bit-in / 16-bit-out datapath-plus-external-controller pair and is the block the top level instantiates directly.

## Interface
Parameters:
- N_W, default 8: operand width of x; legal range 1..16.
- R_W, default 16: result width; legal range 2..64.

Ports:
- clk  in  1  clock; every register updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a computation; sampled only while ready=1.
- abort  in  1  synchronous abort of a running computation.
- x  in  N_W  operand; captured on the accepting edge.
- ready  out  1  high in IDLE; start is accepted only when ready=1.
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse, high in the DONE state.
- result  out  R_W  x! or saturated all-ones; holds its value until the next DONE.
- overflow  out  1  set when result saturated; cleared on the next accepted start.

## Operation
- Internal registers:
  - x_q (N_W): captured operand.
  - i (N_W): counter.
  - fi (R_W): running product.
  - state: IDLE, RUN or DONE.
- IDLE:
  - ready=1.
  - If start=1: x_q<=x, i<=1, fi<=1, overflow<=0, state<=RUN.
- RUN:
  - busy=1.
  - Priority is abort > termination > step.
  - abort=1: state<=IDLE. result and overflow are not updated, and there is no done.
  - i >= x_q: state<=DONE, result<=fi.
  - Otherwise, form p = fi * (i+1) at full width R_W+N_W+1:
    - If p[top:R_W] is nonzero: result<=all-ones, overflow<=1, state<=DONE.
    - Else: fi<=p[R_W-1:0], i<=i+1.
- DONE:
  - done=1 for exactly one cycle; state<=IDLE.
  - start and abort are ignored in DONE.
- Arithmetic:
  - i+1 is computed N_W+1 bits wide.
  - i never exceeds x_q, so the counter cannot wrap. x = 2^N_W-1 is legal.
  - All values are unsigned.
- x=0 and x=1 both yield result=1.
- start while busy or in DONE is ignored. It is not queued.
- Changes on x after the accepting edge have no effect.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, so ready=1, busy=0, done=0.
  - result=0, overflow=0, fi=0, i=0, x_q=0.
  - Deassertion is synchronous to clk in the surrounding design; the first accept can occur on the first edge after release.
- Reset mid-RUN or mid-DONE aborts immediately. No done is produced.
- Latency, counting edge E0 as the edge that accepts start:
  - Non-overflow: the RUN->DONE decision happens at edge E(max(x,1)).
  - done and the new result are visible in the cycle after that edge, i.e. max(x,1)+1 cycles after start was sampled.
  - Overflow: DONE is entered at the edge that computes the first overflowing product.
- ready falls in the cycle after the accepting edge.
- ready rises in the cycle after done. Back-to-back operation is therefore possible with a one-cycle gap (the DONE cycle).
- The multiplier is combinational within one cycle. There are no multicycle paths.

## Test plan
- Reset check: rst_n low mid-run at x=6 -> outputs immediately ready=1, busy=0, done=0, result=0, overflow=0. After release, start with x=3 -> result=6.
- Basic run, N_W=8, R_W=16: start with x=5 -> busy for 5 cycles; done pulses once, 6 cycles after the start sample; result=120, overflow=0. Repeat with x=8 -> result=40320.
- Corner operands: x=0 -> result=1, done 2 cycles after start. x=1 -> identical.
- Overflow, R_W=16: x=9 -> done after edge E8, result=16'hFFFF, overflow=1. A following start with x=4 -> overflow clears on accept, result=24.
- Abort: start x=7, abort=1 on the 3rd RUN cycle -> IDLE next cycle, no done, result still holds the previous value (24).
- Protocol: start held high through the whole run with x changed mid-run -> only one computation, using the x captured at accept. A second start is accepted only after ready returns. Run the same checks with parameters N_W=4, R_W=32 and x=15 -> result=15! = 1307674368000 saturates, overflow=1 (15! exceeds 2^32).
